// File: rtl/bcd2bin_fsm_pkg.sv
// Shared definitions for the BCD/binary conversion blocks.
// Holds the default sizes, the FSM state encoding and the digit legality check.
package bcd2bin_fsm_pkg;

  localparam int DIGITS_DEF = 4;
  localparam int BIN_W_DEF  = 14;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic digit_ok(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble correction for one BCD digit after a right shift.
// A digit that reads 8 or more received a carry of 10 worth 8, so take 3 back.
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= 4'd8) ? (digit - 4'd3) : digit;

endmodule

// File: rtl/bcd2bin_fsm.sv
// Sequential BCD-to-binary converter using reverse double-dabble,
// one shift/adjust step per clock, with start/busy/done handshake and digit check.
module bcd2bin_fsm
  import bcd2bin_fsm_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W  = BIN_W_DEF
) (
  input  logic                clk100Mhz,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd,
  output logic [BIN_W-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int SR_W  = 4*DIGITS + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_t             state_r, state_nxt_s;
  logic [SR_W-1:0]    sreg_r, sreg_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic [BIN_W-1:0]   bin_r, bin_nxt_s;
  logic               err_r, err_nxt_s;
  logic               busy_r, done_r;
  logic [SR_W-1:0]    shr_s, adj_s;
  logic               bcd_bad_s;

  assign shr_s = sreg_r >> 1;
  assign adj_s[BIN_W-1:0] = shr_s[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (shr_s[BIN_W + 4*g +: 4]),
      .adjusted (adj_s[BIN_W + 4*g +: 4])
    );
  end

  // Flag any input digit outside 0..9.
  always_comb begin
    bcd_bad_s = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!digit_ok(bcd[4*i +: 4])) begin
        bcd_bad_s = 1'b1;
      end else begin
        bcd_bad_s = bcd_bad_s;
      end
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt_s = state_r;
    sreg_nxt_s  = sreg_r;
    cnt_nxt_s   = cnt_r;
    bin_nxt_s   = bin_r;
    err_nxt_s   = err_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if (bcd_bad_s) begin
            err_nxt_s   = 1'b1;
            state_nxt_s = S_DONE;
          end else begin
            err_nxt_s   = 1'b0;
            sreg_nxt_s  = {bcd, {BIN_W{1'b0}}};
            cnt_nxt_s   = {CNT_W{1'b0}};
            state_nxt_s = S_SHIFT;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_SHIFT: begin
        sreg_nxt_s = adj_s;
        cnt_nxt_s  = cnt_r + CNT_W'(1);
        // The binary result has fully arrived in the low bits after the last step.
        if (cnt_r == CNT_LAST) begin
          bin_nxt_s   = adj_s[BIN_W-1:0];
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_SHIFT;
        end
      end
      S_DONE: begin
        state_nxt_s = S_IDLE;
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk100Mhz) begin
    if (rst) begin
      state_r <= S_IDLE;
      sreg_r  <= {SR_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      bin_r   <= {BIN_W{1'b0}};
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      sreg_r  <= sreg_nxt_s;
      cnt_r   <= cnt_nxt_s;
      bin_r   <= bin_nxt_s;
      err_r   <= err_nxt_s;
      busy_r  <= (state_r == S_SHIFT);
      done_r  <= (state_r == S_DONE);
    end
  end

  assign bin  = bin_r;
  assign busy = busy_r;
  assign done = done_r;
  assign err  = err_r;

endmodule

// File: tb/tb_bcd2bin_fsm.sv
// Self-checking bench for bcd2bin_fsm: vector table, random conversions against
// a decimal reference model, reset-during-conversion and back-to-back sequences.
module tb_bcd2bin_fsm;

  logic        clk100Mhz;
  logic        rst;
  logic        start;
  logic [15:0] bcd;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic        err;

  int checks;
  int failures;
  logic [13:0] last_good;

  bcd2bin_fsm dut (
    .clk100Mhz (clk100Mhz),
    .rst       (rst),
    .start     (start),
    .bcd       (bcd),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial begin
    clk100Mhz = 1'b0;
    forever #5 clk100Mhz = ~clk100Mhz;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] v;
    logic [13:0] exp_bin;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain decimal weighting of the digits; any digit above 9 is an error.
  task automatic ref_conv(input logic [15:0] v, output logic [13:0] b, output logic e);
    int acc;
    int w;
    acc = 0;
    w = 1;
    e = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] > 4'd9) e = 1'b1;
      acc = acc + w * int'(v[4*i +: 4]);
      w = w * 10;
    end
    b = e ? last_good : acc[13:0];
  endtask

  task automatic do_conv(input logic [15:0] v, input logic [13:0] eb, input logic ee,
                         input string tag);
    int busy_cnt;
    int done_at;
    int done_cnt;
    logic [13:0] bin_at;
    logic err_at;
    busy_cnt = 0;
    done_at  = -1;
    done_cnt = 0;
    bin_at   = 14'd0;
    err_at   = 1'b0;
    @(negedge clk100Mhz);
    bcd   = v;
    start = 1'b1;
    @(posedge clk100Mhz);
    #1;
    start = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      @(posedge clk100Mhz);
      #1;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = i;
          bin_at  = bin;
          err_at  = err;
        end
      end
    end
    chk({tag, " latency"}, done_at, ee ? 32'd1 : 32'd15);
    chk({tag, " done_pulses"}, done_cnt, 32'd1);
    chk({tag, " busy_cycles"}, busy_cnt, ee ? 32'd0 : 32'd14);
    chk({tag, " bin"}, {18'd0, bin_at}, {18'd0, eb});
    chk({tag, " err"}, {31'd0, err_at}, {31'd0, ee});
    if (!ee) last_good = eb;
  endtask

  initial begin
    vec_t vecs[8];
    logic [15:0] rv;
    logic [13:0] rb;
    logic        re;
    int          done_cnt;
    int          done_pos[$];

    checks    = 0;
    failures  = 0;
    last_good = 14'd0;
    rst   = 1'b1;
    start = 1'b0;
    bcd   = 16'h0000;

    vecs[0] = '{16'h7850, 14'h1EAA, 1'b0};
    vecs[1] = '{16'h0012, 14'd12,   1'b0};
    vecs[2] = '{16'h9999, 14'h270F, 1'b0};
    vecs[3] = '{16'h12A4, 14'h270F, 1'b1};
    vecs[4] = '{16'h0000, 14'd0,    1'b0};
    vecs[5] = '{16'h000A, 14'd0,    1'b1};
    vecs[6] = '{16'h8001, 14'h1F41, 1'b0};
    vecs[7] = '{16'hF999, 14'h1F41, 1'b1};

    #20;
    rst = 1'b0;
    #1;
    chk("reset bin",  {18'd0, bin}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset err",  {31'd0, err}, 32'd0);

    foreach (vecs[k]) begin
      do_conv(vecs[k].v, vecs[k].exp_bin, vecs[k].exp_err, $sformatf("vec%0d", k));
    end

    for (int n = 0; n < 150; n++) begin
      for (int d = 0; d < 4; d++) begin
        if ($urandom_range(0, 15) == 0) rv[4*d +: 4] = 4'($urandom_range(10, 15));
        else rv[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      ref_conv(rv, rb, re);
      do_conv(rv, rb, re, $sformatf("rnd%0d_%h", n, rv));
    end

    // Reset during the 7th shift cycle: everything clears, no done follows.
    do_conv(16'h4321, 14'd4321, 1'b0, "pre_rst");
    @(negedge clk100Mhz);
    bcd   = 16'h5555;
    start = 1'b1;
    @(posedge clk100Mhz);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk100Mhz);
    #1;
    chk("mid busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk100Mhz);
    #1;
    rst = 1'b0;
    chk("rst bin",  {18'd0, bin}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    last_good = 14'd0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk100Mhz);
      #1;
      if (done || busy) done_cnt++;
    end
    chk("rst no_activity", done_cnt, 32'd0);

    // start held high: period of 16 cycles; bcd changes mid-shift are ignored.
    @(negedge clk100Mhz);
    bcd   = 16'h7850;
    start = 1'b1;
    @(posedge clk100Mhz);
    #1;
    for (int i = 1; i <= 48; i++) begin
      @(posedge clk100Mhz);
      #1;
      if (i == 5 || i == 21) bcd = 16'h0001;
      if (i == 12 || i == 28) bcd = 16'h7850;
      if (done) begin
        done_pos.push_back(i);
        chk($sformatf("b2b bin@%0d", i), {18'd0, bin}, 32'h1EAA);
        chk($sformatf("b2b err@%0d", i), {31'd0, err}, 32'd0);
      end
    end
    start = 1'b0;
    chk("b2b pulses", done_pos.size(), 32'd3);
    if (done_pos.size() == 3) begin
      chk("b2b first",  done_pos[0], 32'd15);
      chk("b2b period1", done_pos[1] - done_pos[0], 32'd16);
      chk("b2b period2", done_pos[2] - done_pos[1], 32'd16);
    end
    repeat (20) @(posedge clk100Mhz);
    #1;
    chk("b2b idle busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
